// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/issue sequencer owning the PC; resolves BRA/HLT locally.
module instr_sequencer #(
    parameter int IRW = 32,
    parameter int MINDW = 12,
    parameter int PSRW = 5,
    parameter int OPW = 4,
    parameter int IR_OP = 28,
    parameter int IR_CC = 24,
    parameter logic [OPW-1:0] BRA = 4'b0011,
    parameter logic [OPW-1:0] HLT = 4'b1000,
    parameter logic [MINDW-1:0] START_PC = '0,
    parameter int WDT_CYCLES = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             mem_req,
    output logic [MINDW-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [IRW-1:0]   mem_rdata,
    output logic [IRW-1:0]   ir_out,
    output logic             ir_valid,
    input  logic             ex_done,
    input  logic [PSRW-1:0]  psr_in,
    output logic [MINDW-1:0] pc,
    output logic             busy,
    output logic             halted,
    output logic             fault
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        EXEC  = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t           state, state_d;
    logic [MINDW-1:0] pc_q, pc_d;
    logic [PSRW-1:0]  psr_q, psr_d;
    logic [IRW-1:0]   ir_q, ir_q_d;
    logic [IRW-1:0]   ir_hold, ir_hold_d;
    logic [OPW-1:0]   fetch_op;
    logic [3:0]       fetch_cc;

`ifdef SEQ_WATCHDOG_EN
    localparam int WDW = ($clog2(WDT_CYCLES) + 1 > 8) ? $clog2(WDT_CYCLES) + 1 : 8;
    localparam logic [WDW-1:0] WDT_LAST = WDW'(WDT_CYCLES - 1);
    logic [WDW-1:0] wdt_q, wdt_d;
    logic           fault_q, fault_d;
`endif

    function automatic logic cc_taken(input logic [3:0] cc, input logic [PSRW-1:0] f);
        case (cc)
            4'd0:    cc_taken = 1'b1;
            4'd1:    cc_taken = f[1];
            4'd2:    cc_taken = f[2];
            4'd3:    cc_taken = f[0];
            4'd4:    cc_taken = f[3];
            4'd5:    cc_taken = f[4];
            4'd6:    cc_taken = ~f[0];
            4'd7:    cc_taken = ~f[3];
            default: cc_taken = 1'b0;
        endcase
    endfunction

    assign fetch_op = mem_rdata[IR_OP +: OPW];
    assign fetch_cc = mem_rdata[IR_CC +: 4];

    always_comb begin
        state_d   = state;
        pc_d      = pc_q;
        psr_d     = psr_q;
        ir_q_d    = ir_q;
        ir_hold_d = ir_hold;
`ifdef SEQ_WATCHDOG_EN
        wdt_d     = wdt_q;
        fault_d   = fault_q;
`endif
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = START_PC;
                    psr_d   = '0;
`ifdef SEQ_WATCHDOG_EN
                    fault_d = 1'b0;
`endif
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    ir_q_d = mem_rdata;
                    if (fetch_op == HLT) begin
                        state_d = HALT;
                    end else if (fetch_op == BRA) begin
                        pc_d = cc_taken(fetch_cc, psr_q) ? mem_rdata[MINDW-1:0] : pc_q + MINDW'(1);
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d   = EXEC;
                ir_hold_d = ir_q;
`ifdef SEQ_WATCHDOG_EN
                wdt_d     = '0;
`endif
            end
            EXEC: begin
                if (ex_done) begin
                    state_d = FETCH;
                    psr_d   = psr_in;
                    pc_d    = pc_q + MINDW'(1);
                end
`ifdef SEQ_WATCHDOG_EN
                else if (wdt_q == WDT_LAST) begin
                    state_d = HALT;
                    fault_d = 1'b1;
                end else begin
                    wdt_d = wdt_q + WDW'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc_q    <= '0;
            psr_q   <= '0;
            ir_q    <= '0;
            ir_hold <= '0;
        end else begin
            state   <= state_d;
            pc_q    <= pc_d;
            psr_q   <= psr_d;
            ir_q    <= ir_q_d;
            ir_hold <= ir_hold_d;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            wdt_q   <= wdt_d;
            fault_q <= fault_d;
        end
    end
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign mem_req  = (state == FETCH);
    assign mem_addr = mem_req ? pc_q : '0;
    assign ir_valid = (state == ISSUE);
    assign ir_out   = ir_valid ? ir_q : ir_hold;
    assign pc       = pc_q;
    assign busy     = (state == FETCH) || (state == ISSUE) || (state == EXEC);
    assign halted   = (state == HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - self-checking bench for instr_sequencer (tables, hand sequences, random vs ISA model).
module tb_instr_sequencer;

    localparam logic [3:0]  OP_BRA = 4'b0011;
    localparam logic [3:0]  OP_HLT = 4'b1000;
    localparam logic [31:0] W_HLT  = 32'h8000_0000;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic        mem_ack = 1'b0, ex_done = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [4:0]  psr_in = '0;
    logic        mem_req, ir_valid, busy, halted, fault;
    logic [11:0] mem_addr, pc;
    logic [31:0] ir_out;

    instr_sequencer #(.WDT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir_out(ir_out), .ir_valid(ir_valid), .ex_done(ex_done), .psr_in(psr_in),
        .pc(pc), .busy(busy), .halted(halted), .fault(fault)
    );

    initial forever #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [31:0] mem [0:4095];
    bit   mem_auto = 1'b1, ex_auto = 1'b1;
    int   mem_wait = 0, ex_lat = 0;
    logic force_ack = 1'b0, force_done = 1'b0;
    logic [4:0] force_psr = '0;
    logic [11:0] fa_q[$];
    int   ac_q[$], rq_q[$], iv_q[$];
    logic [31:0] issued[$];
    logic [31:0] exp_q[$];
    int   halt_cyc = 0, cyc = 0;

    initial begin : resp
        int wcnt, ecnt, reqn;
        bit epend, hprev;
        logic [31:0] lastw;
        wcnt = 0; ecnt = 0; reqn = 0; epend = 0; hprev = 0; lastw = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (halted && !hprev) halt_cyc = cyc;
            hprev = halted;
            if (mem_req) reqn++; else reqn = 0;
            if (mem_auto) begin
                mem_ack = 1'b0;
                if (mem_req) begin
                    if (wcnt == mem_wait) begin mem_ack = 1'b1; wcnt = 0; end
                    else wcnt++;
                end else wcnt = 0;
            end else begin
                mem_ack = force_ack;
                wcnt = 0;
            end
            mem_rdata = mem[mem_addr];
            if (mem_ack && mem_req) begin
                fa_q.push_back(mem_addr); ac_q.push_back(cyc); rq_q.push_back(reqn); reqn = 0;
            end
            if (!busy) epend = 0;
            if (ir_valid) begin
                issued.push_back(ir_out); iv_q.push_back(cyc); lastw = ir_out; epend = 1; ecnt = 0;
            end
            if (ex_auto) begin
                ex_done = 1'b0;
                if (epend && !ir_valid) begin
                    if (ecnt == ex_lat) begin ex_done = 1'b1; psr_in = lastw[4:0]; epend = 0; end
                    else ecnt++;
                end
            end else begin
                ex_done = force_done;
                psr_in = force_psr;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fill_hlt();
        for (int i = 0; i < 4096; i++) mem[i] = W_HLT;
    endtask

    task automatic clear_rec();
        fa_q.delete(); ac_q.delete(); rq_q.delete(); iv_q.delete(); issued.delete();
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_halt(input string nm, input int lim);
        int n;
        n = 0;
        while (!halted && n < lim) begin @(negedge clk); n++; end
        chk({nm, " halted"}, 32'(halted), 32'd1);
    endtask

    task automatic wait_iv(input string nm, input int lim);
        int n;
        n = 0;
        while (!ir_valid && n < lim) begin @(negedge clk); n++; end
        chk({nm, " ir_valid"}, 32'(ir_valid), 32'd1);
    endtask

    task automatic pulse_ack();
        @(posedge clk); #1 force_ack = 1'b1;
        @(posedge clk); #1 force_ack = 1'b0;
    endtask

    task automatic pulse_done();
        @(posedge clk); #1 force_done = 1'b1;
        @(posedge clk); #1 force_done = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    function automatic bit model_taken(input logic [3:0] cc, input logic [4:0] f);
        int sel [8];
        sel = '{0, 1, 2, 0, 3, 4, 0, 3};
        if (cc > 4'd7) return 1'b0;
        if (cc == 4'd0) return 1'b1;
        return (cc >= 4'd6) ? !f[sel[cc]] : f[sel[cc]];
    endfunction

    task automatic model_run(input logic [11:0] spc, output logic [11:0] fpc);
        logic [11:0] p;
        logic [4:0]  f;
        logic [31:0] w;
        p = spc; f = '0;
        exp_q.delete();
        for (int s = 0; s < 1000; s++) begin
            w = mem[p];
            if (w[31:28] == OP_HLT) break;
            if (w[31:28] == OP_BRA) p = model_taken(w[27:24], f) ? w[11:0] : p + 12'd1;
            else begin exp_q.push_back(w); f = w[4:0]; p = p + 12'd1; end
        end
        fpc = p;
    endtask

    typedef struct {
        logic [3:0] cc;
        logic [4:0] psr;
        bit         taken;
    } vec_t;

    initial begin
        vec_t vt [18];
        logic [11:0] epc;
        logic [3:0]  op;
        vt = '{
            '{4'd0, 5'b00000, 1'b1}, '{4'd1, 5'b00010, 1'b1}, '{4'd1, 5'b11101, 1'b0},
            '{4'd2, 5'b00100, 1'b1}, '{4'd2, 5'b11011, 1'b0}, '{4'd3, 5'b00001, 1'b1},
            '{4'd3, 5'b11110, 1'b0}, '{4'd4, 5'b01000, 1'b1}, '{4'd4, 5'b10111, 1'b0},
            '{4'd5, 5'b10000, 1'b1}, '{4'd5, 5'b00000, 1'b0}, '{4'd6, 5'b11110, 1'b1},
            '{4'd6, 5'b00001, 1'b0}, '{4'd7, 5'b10111, 1'b1}, '{4'd7, 5'b01000, 1'b0},
            '{4'd8, 5'b11111, 1'b0}, '{4'd12, 5'b11111, 1'b0}, '{4'd15, 5'b00000, 1'b0}
        };
        fill_hlt();

        repeat (3) @(negedge clk);
        chk("rst mem_req", 32'(mem_req), 0);   chk("rst mem_addr", 32'(mem_addr), 0);
        chk("rst ir_out", ir_out, 0);          chk("rst ir_valid", 32'(ir_valid), 0);
        chk("rst pc", 32'(pc), 0);             chk("rst busy", 32'(busy), 0);
        chk("rst halted", 32'(halted), 0);     chk("rst fault", 32'(fault), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle busy", 32'(busy), 0);

        mem[0] = 32'h1000_0123; mem[1] = 32'h20AB_CDE0;
        clear_rec();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 0;
        chk("start mem_req", 32'(mem_req), 1); chk("start mem_addr", 32'(mem_addr), 0);
        wait_halt("straight", 200);
        chk("straight issues", 32'(issued.size()), 2);
        chk("straight word0", issued[0], 32'h1000_0123);
        chk("straight word1", issued[1], 32'h20AB_CDE0);
        chk("straight pc", 32'(pc), 2);        chk("straight busy", 32'(busy), 0);
        chk("ack->ir_valid", 32'(iv_q[0] - ac_q[0]), 1);
        chk("ack->next ack", 32'(ac_q[1] - ac_q[0]), 3);
        chk("hlt ack->halted", 32'(halt_cyc - ac_q[2]), 1);
        chk("ir_out hold", ir_out, 32'h20AB_CDE0);

        foreach (vt[i]) begin
            fill_hlt();
            mem[0] = {4'h1, 23'h0, vt[i].psr};
            mem[1] = {OP_BRA, vt[i].cc, 12'h000, 12'h040};
            clear_rec();
            do_start();
            wait_halt("bra", 200);
            chk($sformatf("bra cc%0d psr%b pc", vt[i].cc, vt[i].psr), 32'(pc), vt[i].taken ? 32'h040 : 32'h002);
            chk($sformatf("bra cc%0d next addr", vt[i].cc), 32'(fa_q[2]), vt[i].taken ? 32'h040 : 32'h002);
            chk("bra fetch spacing", 32'(ac_q[2] - ac_q[1]), 1);
            chk("bra not issued", 32'(issued.size()), 1);
        end

        fill_hlt();
        mem[0] = {OP_BRA, 4'd3, 12'h000, 12'h100};
        mem[1] = {4'h1, 23'h0, 5'b10000};
        mem[2] = {OP_BRA, 4'd5, 12'h000, 12'hFFF};
        mem[12'hFFF] = {4'h2, 23'h0, 5'b00001};
        mem_wait = 3;
        clear_rec();
        do_start();
        wait_halt("wrap", 500);
        chk("wrap fetch FFF", 32'(fa_q[3]), 32'hFFF);
        chk("wrap req cycles", 32'(rq_q[3]), 4);
        chk("wrap next addr", 32'(fa_q[4]), 0);
        chk("wrap pc", 32'(pc), 32'h100);
        chk("wrap issues", 32'(issued.size()), 2);
        mem_wait = 0;

        fill_hlt();
        mem[0] = 32'h5000_0011;
        ex_auto = 1'b0;
        clear_rec();
        do_start();
        wait_iv("spur", 50);
        @(posedge clk); #1 mem_auto = 1'b0;
        pulse_ack();
        chk("spur ack pc", 32'(pc), 0);        chk("spur ack busy", 32'(busy), 1);
        chk("spur ack mem_req", 32'(mem_req), 0);
        pulse_start();
        chk("spur start pc", 32'(pc), 0);      chk("spur start mem_req", 32'(mem_req), 0);
        chk("spur iv count", 32'(issued.size()), 1);
        pulse_done();
        chk("done mem_req", 32'(mem_req), 1);  chk("done mem_addr", 32'(mem_addr), 1);
        pulse_done();
        chk("spur done pc", 32'(pc), 1);       chk("spur done mem_req", 32'(mem_req), 1);
        pulse_start();
        chk("spur start2 pc", 32'(pc), 1);     chk("spur start2 mem_req", 32'(mem_req), 1);
        pulse_ack();
        chk("spur halted", 32'(halted), 1);    chk("spur halt pc", 32'(pc), 1);
        mem_auto = 1'b1;

        fill_hlt();
        mem[0] = 32'h6000_0002;
        clear_rec();
        do_start();
        wait_iv("arst", 50);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("arst busy", 32'(busy), 0);        chk("arst pc", 32'(pc), 0);
        chk("arst ir_out", ir_out, 0);         chk("arst halted", 32'(halted), 0);
        chk("arst mem_req", 32'(mem_req), 0);
        @(negedge clk) rst_n = 1'b1;
        mem_auto = 1'b0;
        pulse_done();
        pulse_ack();
        chk("post-rst busy", 32'(busy), 0);    chk("post-rst halted", 32'(halted), 0);
        chk("post-rst mem_req", 32'(mem_req), 0);
        mem_auto = 1'b1;

        clear_rec();
        do_start();
        wait_iv("wdt", 50);
`ifdef SEQ_WATCHDOG_EN
        wait_halt("wdt", 200);
        chk("wdt exec cycles", 32'(halt_cyc - (iv_q[0] + 1)), 16);
        chk("wdt fault", 32'(fault), 1);
        mem[0] = W_HLT;
        do_start();
        chk("wdt fault cleared", 32'(fault), 0);
        wait_halt("wdt restart", 50);
`else
        repeat (1000) @(negedge clk);
        chk("nowdt busy", 32'(busy), 1);       chk("nowdt halted", 32'(halted), 0);
        chk("nowdt fault", 32'(fault), 0);
        pulse_done();
        wait_halt("nowdt end", 50);
        chk("nowdt pc", 32'(pc), 1);
`endif
        ex_auto = 1'b1;

        for (int t = 0; t < 8; t++) begin
            fill_hlt();
            for (int a = 0; a < 32; a++) begin
                if ($urandom_range(0, 2) == 0) begin
                    mem[a] = {OP_BRA, 4'($urandom_range(0, 15)), 12'($urandom), 12'($urandom_range(a + 1, 40))};
                end else begin
                    do op = 4'($urandom); while (op == OP_BRA || op == OP_HLT);
                    mem[a] = {op, 28'($urandom)};
                end
            end
            mem_wait = $urandom_range(0, 2);
            ex_lat = $urandom_range(0, 3);
            model_run(12'h000, epc);
            clear_rec();
            do_start();
            wait_halt("rand", 3000);
            chk($sformatf("rand%0d pc", t), 32'(pc), 32'(epc));
            chk($sformatf("rand%0d issues", t), 32'(issued.size()), 32'(exp_q.size()));
            foreach (exp_q[i]) chk($sformatf("rand%0d word%0d", t, i), issued[i], exp_q[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
